// File: rtl/instr_mem_loader.sv
// Byte-stream instruction memory writer: packs little-endian bytes into words and holds the CPU in reset while loading.
// Define LOADER_CHECKSUM_EN to require a 4-byte trailer that must equal the 32-bit sum of all written words.
module instr_mem_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  cpu_hold,
  output logic                  err_overflow,
  output logic                  chk_err
);

  localparam logic [ADDR_WIDTH:0]   DEPTH    = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   WIDE_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    DONE
`ifdef LOADER_CHECKSUM_EN
    , CHECK
`endif
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t LOAD_END = CHECK;
`else
  localparam state_t LOAD_END = DONE;
`endif

  state_t                state, state_next;
  logic [ADDR_WIDTH:0]   n_words;
  logic [ADDR_WIDTH:0]   n_clamped;
  logic [ADDR_WIDTH-1:0] addr;
  logic [1:0]            byte_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  busy_q;
  logic                  overflow_q;
  logic                  accept_start;
  logic                  xfer;
  logic                  word_complete;
  logic                  last_word;

`ifdef LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum;
  logic [DATA_WIDTH-1:0] trail;
  logic                  chk_q;
`endif

  assign accept_start  = start && ((state == IDLE) || (state == DONE));
`ifdef LOADER_CHECKSUM_EN
  assign byte_ready    = (state == RECV) || (state == CHECK);
`else
  assign byte_ready    = (state == RECV);
`endif
  assign xfer          = byte_valid && byte_ready;
  assign word_complete = xfer && (byte_cnt == 2'd3);
  assign n_clamped     = (word_count > DEPTH) ? DEPTH : word_count;
  assign last_word     = (({1'b0, addr} + WIDE_ONE) == n_words);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (accept_start) state_next = (n_clamped == '0) ? LOAD_END : RECV;
      end
      RECV:  if (word_complete) state_next = WRITE;
      WRITE: state_next = last_word ? LOAD_END : RECV;
`ifdef LOADER_CHECKSUM_EN
      CHECK: if (word_complete) state_next = DONE;
`endif
      default: state_next = IDLE;
    endcase
  end

  // On the final word the index is left in place so mem_addr keeps the last written address.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      n_words    <= '0;
      addr       <= '0;
      byte_cnt   <= '0;
      shift_reg  <= '0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum        <= '0;
      trail      <= '0;
      chk_q      <= 1'b0;
`endif
    end else begin
      busy_q <= (state_next != IDLE) && (state_next != DONE);
      if (accept_start) begin
        n_words    <= n_clamped;
        overflow_q <= (word_count > DEPTH);
        addr       <= '0;
        byte_cnt   <= '0;
`ifdef LOADER_CHECKSUM_EN
        sum        <= '0;
        chk_q      <= 1'b0;
`endif
      end
      if (xfer) begin
        byte_cnt <= byte_cnt + 2'd1;
        if (state == RECV) shift_reg <= {byte_in, shift_reg[DATA_WIDTH-1:8]};
`ifdef LOADER_CHECKSUM_EN
        else begin
          trail <= {byte_in, trail[DATA_WIDTH-1:8]};
          if (word_complete) chk_q <= ({byte_in, trail[DATA_WIDTH-1:8]} != sum);
        end
`endif
      end
      if (state == WRITE) begin
`ifdef LOADER_CHECKSUM_EN
        sum <= sum + shift_reg;
`endif
        if (!last_word) addr <= addr + ADDR_ONE;
      end
    end
  end

  assign mem_we       = (state == WRITE);
  assign mem_addr     = {{(32-ADDR_WIDTH){1'b0}}, addr};
  assign mem_wdata    = shift_reg;
  assign busy         = busy_q;
  assign cpu_hold     = busy_q;
  assign done         = (state == DONE);
  assign err_overflow = overflow_q;
`ifdef LOADER_CHECKSUM_EN
  assign chk_err      = chk_q;
`else
  assign chk_err      = 1'b0;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: random and directed loads checked against a word-list model built from the byte stream.
// Checksum scenarios are compiled in when LOADER_CHECKSUM_EN is defined.
module tb_instr_mem_loader;
  localparam int AW    = 10;
  localparam int WCW   = AW + 1;
  localparam int DEPTH = 1 << AW;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [AW:0]    word_count;
  logic [7:0]     byte_in;
  logic           byte_valid;
  logic           byte_ready;
  logic           mem_we;
  logic [31:0]    mem_addr;
  logic [31:0]    mem_wdata;
  logic           busy;
  logic           done;
  logic           cpu_hold;
  logic           err_overflow;
  logic           chk_err;

  int vectors    = 0;
  int miscompares = 0;

  logic [7:0]  tx_bytes[$];
  logic [31:0] exp_data[$];
  logic [31:0] obs_addr[$];
  logic [31:0] obs_data[$];
  logic        exp_chk;
  int          ready_in_write = 0;

  instr_mem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .word_count(word_count),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .cpu_hold(cpu_hold),
    .err_overflow(err_overflow), .chk_err(chk_err)
  );

  always #5 clk = ~clk;

  // Record every memory write half a cycle after the edge that produced it.
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      obs_addr.push_back(mem_addr);
      obs_data.push_back(mem_wdata);
      if (byte_ready) ready_in_write++;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Model: word i is sum of byte(4i+k) * 256^k; the trailer (if any) is the wrapping word sum.
  task automatic model_from_bytes(input int n);
    logic [31:0] w, s;
    exp_data.delete();
    s = 32'd0;
    for (int i = 0; i < n; i++) begin
      w = 32'd0;
      for (int k = 0; k < 4; k++) w = w + 32'(tx_bytes[4*i+k]) * (32'd1 << (8*k));
      exp_data.push_back(w);
      s = s + w;
    end
`ifdef LOADER_CHECKSUM_EN
    for (int k = 0; k < 4; k++) tx_bytes.push_back(8'((s / (32'd1 << (8*k))) % 256));
`endif
    exp_chk = 1'b0;
  endtask

  task automatic make_random_load(input int wc);
    int n;
    n = (wc > DEPTH) ? DEPTH : wc;
    tx_bytes.delete();
    for (int i = 0; i < 4*n; i++) tx_bytes.push_back(8'($urandom));
    model_from_bytes(n);
  endtask

  task automatic clear_obs();
    obs_addr.delete();
    obs_data.delete();
    ready_in_write = 0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    start = 1'b0;
    byte_valid = 1'b0;
    byte_in = 8'h00;
    word_count = '0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    clear_obs();
  endtask

  task automatic do_start(input int wc);
    @(posedge clk);
    #1 start = 1'b1;
    word_count = WCW'(wc);
    @(posedge clk);
    #1 start = 1'b0;
    word_count = WCW'($urandom_range(0, 2047));
  endtask

  // mode 0: valid every cycle, 1: valid every other cycle, 2: random valid. start_at pulses start mid-stream.
  task automatic drive_bytes(input int mode, input int start_at, input int budget);
    int idx = 0;
    int cyc = 0;
    logic accepted;
    while (idx < tx_bytes.size() && cyc < budget) begin
      case (mode)
        0:       byte_valid = 1'b1;
        1:       byte_valid = (cyc % 2 == 0);
        default: byte_valid = 1'($urandom_range(0, 1));
      endcase
      byte_in = byte_valid ? tx_bytes[idx] : 8'($urandom);
      start = (idx == start_at);
      if (start) word_count = WCW'(7);
      accepted = byte_valid && byte_ready;
      @(posedge clk);
      #1 cyc++;
      if (accepted) idx++;
    end
    byte_valid = 1'b0;
    start = 1'b0;
    if (idx < tx_bytes.size()) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL byte_stream: accepted %0d bytes, required %0d within %0d cycles", idx, tx_bytes.size(), budget);
    end
  endtask

  task automatic wait_done(input int budget);
    int c = 0;
    while (!done && c < budget) begin
      @(posedge clk);
      #1 c++;
    end
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL done_timeout: done=%b after %0d cycles, required 1", done, c);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 vectors++;
      if ({byte_ready, mem_we, busy, done, cpu_hold, err_overflow, chk_err, mem_addr, mem_wdata} !== '0) begin
        miscompares++;
        $display("[TB] FAIL reset_idle: ready=%b we=%b busy=%b done=%b hold=%b ovf=%b chk=%b addr=%h data=%h, required all 0",
                 byte_ready, mem_we, busy, done, cpu_hold, err_overflow, chk_err, mem_addr, mem_wdata);
      end
    end
    vectors++;
    if (obs_data.size() !== 0) begin
      miscompares++;
      $display("[TB] FAIL reset_no_write: %0d writes seen, required 0", obs_data.size());
    end
  endtask

  task automatic test_directed(input int mode);
    clear_obs();
    tx_bytes = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h80, 8'h20, 8'h00};
    model_from_bytes(2);
    do_start(2);
    vectors++;
    if (cpu_hold !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL hold_rise: busy=%b cpu_hold=%b, required 1/1", busy, cpu_hold);
    end
    drive_bytes(mode, -1, 100);
    wait_done(10);
    vectors++;
    if (obs_data.size() !== 2) begin
      miscompares++;
      $display("[TB] FAIL directed_count(mode %0d): %0d writes, required 2", mode, obs_data.size());
    end
    for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
      vectors++;
      if (obs_addr[i] !== 32'(i) || obs_data[i] !== exp_data[i]) begin
        miscompares++;
        $display("[TB] FAIL directed_write(mode %0d): got addr=%0d data=%h, required addr=%0d data=%h",
                 mode, obs_addr[i], obs_data[i], i, exp_data[i]);
      end
    end
    vectors++;
    if (done !== 1'b1 || cpu_hold !== 1'b0 || busy !== 1'b0 || ready_in_write !== 0) begin
      miscompares++;
      $display("[TB] FAIL directed_end(mode %0d): done=%b hold=%b busy=%b ready_in_write=%0d, required 1/0/0/0",
               mode, done, cpu_hold, busy, ready_in_write);
    end
  endtask

  task automatic test_zero_count();
    clear_obs();
    tx_bytes.delete();
    model_from_bytes(0);
    do_start(0);
`ifdef LOADER_CHECKSUM_EN
    drive_bytes(0, -1, 50);
    wait_done(10);
`else
    @(posedge clk);
    #1;
`endif
    vectors++;
    if (done !== 1'b1 || obs_data.size() !== 0 || chk_err !== exp_chk || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL zero_count: done=%b writes=%0d chk=%b busy=%b, required 1/0/%b/0",
               done, obs_data.size(), chk_err, busy, exp_chk);
    end
  endtask

  task automatic test_start_ignored();
    clear_obs();
    make_random_load(3);
    do_start(3);
    drive_bytes(0, 5, 200);
    wait_done(10);
    vectors++;
    if (obs_data.size() !== 3) begin
      miscompares++;
      $display("[TB] FAIL start_ignored_count: %0d writes, required 3", obs_data.size());
    end
    for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
      vectors++;
      if (obs_addr[i] !== 32'(i) || obs_data[i] !== exp_data[i]) begin
        miscompares++;
        $display("[TB] FAIL start_ignored_write: got addr=%0d data=%h, required addr=%0d data=%h",
                 obs_addr[i], obs_data[i], i, exp_data[i]);
      end
    end
  endtask

  task automatic test_random_loads();
    int wc, mode;
    for (int t = 0; t < 6; t++) begin
      clear_obs();
      wc = $urandom_range(1, 6);
      mode = $urandom_range(0, 2);
      make_random_load(wc);
      do_start(wc);
      drive_bytes(mode, -1, 500);
      wait_done(10);
      vectors++;
      if (obs_data.size() !== exp_data.size() || err_overflow !== 1'b0 || chk_err !== exp_chk) begin
        miscompares++;
        $display("[TB] FAIL random_load_%0d: writes=%0d ovf=%b chk=%b, required %0d/0/%b",
                 t, obs_data.size(), err_overflow, chk_err, exp_data.size(), exp_chk);
      end
      for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
        vectors++;
        if (obs_addr[i] !== 32'(i) || obs_data[i] !== exp_data[i]) begin
          miscompares++;
          $display("[TB] FAIL random_write_%0d: got addr=%0d data=%h, required addr=%0d data=%h",
                   t, obs_addr[i], obs_data[i], i, exp_data[i]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    int bad = 0;
    clear_obs();
    make_random_load(1025);
    do_start(1025);
    vectors++;
    if (err_overflow !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL overflow_flag: err_overflow=%b, required 1", err_overflow);
    end
    drive_bytes(0, -1, 6000);
    wait_done(10);
    vectors++;
    if (obs_data.size() !== DEPTH || err_overflow !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL overflow_count: writes=%0d ovf=%b, required %0d/1", obs_data.size(), err_overflow, DEPTH);
    end
    for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++)
      if (obs_addr[i] !== 32'(i) || obs_data[i] !== exp_data[i]) bad++;
    vectors++;
    if (bad != 0 || obs_addr.size() == 0 || obs_addr[obs_addr.size()-1] !== 32'(DEPTH-1)) begin
      miscompares++;
      $display("[TB] FAIL overflow_writes: %0d wrong writes, last addr=%0d, required 0 wrong and last %0d",
               bad, (obs_addr.size() == 0) ? -1 : int'(obs_addr[obs_addr.size()-1]), DEPTH-1);
    end
    clear_obs();
    make_random_load(1);
    do_start(1);
    vectors++;
    if (err_overflow !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL overflow_clear: err_overflow=%b, required 0", err_overflow);
    end
    drive_bytes(0, -1, 50);
    wait_done(10);
  endtask

  task automatic test_reset_mid_load();
    clear_obs();
    make_random_load(4);
    while (tx_bytes.size() > 6) void'(tx_bytes.pop_back());
    do_start(4);
    drive_bytes(0, -1, 50);
    rst_n = 1'b0;
    @(posedge clk);
    #1 vectors++;
    if ({byte_ready, mem_we, busy, done, cpu_hold, err_overflow, chk_err, mem_addr, mem_wdata} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_load: ready=%b we=%b busy=%b done=%b hold=%b addr=%h data=%h, required all 0",
               byte_ready, mem_we, busy, done, cpu_hold, mem_addr, mem_wdata);
    end
    vectors++;
    if (obs_data.size() !== 1 || obs_data[0] !== exp_data[0]) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_kept: writes=%0d first=%h, required 1 write of %h",
               obs_data.size(), (obs_data.size() > 0) ? obs_data[0] : 32'h0, exp_data[0]);
    end
    rst_n = 1'b1;
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum(input logic [7:0] trailer_lsb);
    logic [31:0] trailer;
    clear_obs();
    tx_bytes = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h80, 8'h20, 8'h00};
    model_from_bytes(2);
    tx_bytes[8] = trailer_lsb;
    trailer = 32'd0;
    for (int k = 0; k < 4; k++) trailer = trailer + 32'(tx_bytes[8+k]) * (32'd1 << (8*k));
    exp_chk = (trailer != (exp_data[0] + exp_data[1]));
    do_start(2);
    drive_bytes(1, -1, 100);
    wait_done(10);
    vectors++;
    if (chk_err !== exp_chk || done !== 1'b1 || obs_data.size() !== 2) begin
      miscompares++;
      $display("[TB] FAIL checksum(trailer %h): chk=%b done=%b writes=%0d, required %b/1/2",
               trailer, chk_err, done, obs_data.size(), exp_chk);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed(0);
    test_directed(1);
    test_zero_count();
    test_start_ignored();
    test_random_loads();
    test_overflow();
    test_reset_mid_load();
`ifdef LOADER_CHECKSUM_EN
    apply_reset();
    test_checksum(8'hC6);
    test_checksum(8'hC7);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Writer side of the word-addressed instruction memory: receives a byte stream (e.g. from a UART receiver) over a valid/ready handshake, assembles little-endian 32-bit words and writes them to consecutive word addresses starting at 0.
- Holds the processor in reset (`cpu_hold`) while a program load is in progress.
- Replaces file preloading when running on hardware.

Parameters:
- ADDR_WIDTH, 10, word-address width; memory depth is 2**ADDR_WIDTH = 1024 words.
- DATA_WIDTH, 32, instruction word width; must be 32 (four bytes per word).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous, active-low reset
- start  input  1  single-cycle pulse; begins a load when idle
- word_count  input  ADDR_WIDTH+1  number of words to load; sampled on the accepted start
- byte_in  input  8  incoming byte
- byte_valid  input  1  byte_in valid
- byte_ready  output  1  loader accepts byte this cycle
- mem_we  output  1  memory write strobe, one cycle per word
- mem_addr  output  32  word address (index, not byte address), zero-extended from ADDR_WIDTH
- mem_wdata  output  32  assembled instruction word
- busy  output  1  high from accepted start until DONE is reached
- done  output  1  level; high in DONE until the next accepted start or reset
- cpu_hold  output  1  processor reset request; high while busy
- err_overflow  output  1  sticky; word_count exceeded depth; cleared by the next accepted start or reset
- chk_err  output  1  checksum mismatch (see Optional Feature)

Behaviour:
- Reset (`rst_n`=0 at clk edge): FSM enters IDLE; byte counter=0; word address=0; shift register=0. All outputs are 0.
- FSM states: IDLE, RECV, WRITE, DONE. CHECK is added only with the option.
- IDLE:
  - start=1: latch N = min(word_count, 2**ADDR_WIDTH); set err_overflow if word_count > 2**ADDR_WIDTH.
  - Clear done, address and byte counter.
  - If N=0, go to DONE; otherwise go to RECV.
- RECV:
  - byte_ready=1.
  - A byte transfers when byte_valid && byte_ready. The k-th byte of a word (k=0..3) is placed in bits [8k+7:8k].
  - On the 4th transfer, go to WRITE.
  - byte_valid=0 stalls the loader indefinitely; there is no timeout.
- WRITE (exactly 1 cycle):
  - byte_ready=0.
  - mem_we=1, with mem_addr = current word index and mem_wdata = assembled word.
  - Next cycle: increment the address. If (address+1)==N, go to DONE (or CHECK); otherwise return to RECV.
- DONE: busy=0, cpu_hold=0, done=1. Bytes are not accepted (byte_ready=0). A start pulse begins a new load.
- Latency: a word's mem_we asserts on the cycle after its 4th byte handshake.
- busy and cpu_hold are registered. They rise the cycle after the accepted start and fall on entry to DONE.
- start while busy is ignored. word_count changes after the accepted start are ignored.
- Address wrap: the address never wraps. Clamping N guarantees the last write is at 2**ADDR_WIDTH-1.
- mem_addr and mem_wdata hold their last values outside WRITE; only mem_we qualifies them.
- Reset mid-load: abort immediately; already-written words are not retracted; done stays 0.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Enabled:
  - A 32-bit wrapping sum of all written words accumulates; it is cleared on the accepted start.
  - After the last word, the FSM enters CHECK and receives 4 more bytes (little-endian, byte_ready=1) with no mem_we.
  - On the 4th byte: chk_err = (received != sum), then go to DONE.
  - chk_err is sticky until the next accepted start or reset.
  - N=0 still requires the 4-byte trailer, which must equal 0.
- Disabled: no CHECK state, no trailer; chk_err is tied to 0.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0, byte_ready=0, mem_we never asserted.
- start with word_count=2, bytes 0x13,0x00,0x00,0x00,0xB3,0x80,0x20,0x00 sent back-to-back -> mem_we at addr 0 data 0x00000013, then addr 1 data 0x002080B3; done=1, cpu_hold=0 afterwards.
- Same load with byte_valid toggled on/off every cycle -> identical writes; exactly 2 mem_we pulses; byte_ready=0 during each WRITE cycle.
- start with word_count=0 -> done=1 two cycles after start, no mem_we (option off); start pulsed again mid-load of 3 words -> ignored, exactly 3 writes.
- start with word_count=1025 -> err_overflow=1, 1024 writes (last at addr 1023), then done=1; rst_n=0 during load -> everything returns to 0 next edge.
- LOADER_CHECKSUM_EN: 2 words 0x00000013 and 0x002080B3, trailer 0x002080C6 -> chk_err=0; trailer 0x002080C7 -> chk_err=1, done=1 in both cases.
